// File: rtl/wb_store_buffer_pkg.sv
// Shared types and constants for the write-back stage and its posted store queue.
package wb_store_buffer_pkg;

  // Background drain of the store queue towards the D-cache core bus.
  typedef enum logic [1:0] {
    DS_IDLE,
    DS_REQ,
    DS_WAIT
  } drain_state_e;

  // Entries are sized for the widest supported configuration; narrower
  // instances zero-extend on write and slice on read.
  localparam int SQ_MAX_ADDR_W = 64;
  localparam int SQ_MAX_DATA_W = 64;

  typedef struct packed {
    logic [SQ_MAX_ADDR_W-1:0] addr;
    logic [SQ_MAX_DATA_W-1:0] data;
  } sq_entry_t;

  // D-cache request tag fields, packed MSB-first as {WRITE, MEMORY, DATA, 0...}.
  localparam logic WRITE  = 1'b1;
  localparam logic MEMORY = 1'b1;
  localparam logic DATA   = 1'b1;

endpackage

// File: rtl/wb_store_buffer_if.sv
// D-cache core bus as seen by the store drain: master issues, slave acknowledges.
interface wb_store_buffer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic              reqcyc;
  logic [ADDR_W-1:0] req;
  logic [DATA_W-1:0] reqdata;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack;
  logic              writeack;

  modport master (output reqcyc, req, reqdata, reqtag, input reqack, writeack);
  modport slave  (input reqcyc, req, reqdata, reqtag, output reqack, writeack);
endinterface

// File: rtl/wb_store_buffer_sq_fifo.sv
// Store queue: circular storage, head/tail pointers, occupancy and a line-granular probe CAM.
module wb_store_buffer_sq_fifo
  import wb_store_buffer_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int SQ_DEPTH = 4,
  localparam int PTR_W   = $clog2(SQ_DEPTH),
  localparam int CNT_W   = $clog2(SQ_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic [ADDR_W-1:0] headAddr,
  output logic [DATA_W-1:0] headData,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] probeAddr,
  output logic              probeHit
);

  // Probe compares 8-byte granules: address bits [2:0] are ignored.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(7);

  sq_entry_t          entries [SQ_DEPTH];
  logic [SQ_DEPTH-1:0] entryVld;
  logic [PTR_W-1:0]    headPtr;
  logic [PTR_W-1:0]    tailPtr;

  // Pointer, occupancy and valid-bit bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      entryVld <= '0;
    end else begin
      if (push) begin
        tailPtr           <= tailPtr + PTR_W'(1);
        entryVld[tailPtr] <= 1'b1;
      end
      if (pop) begin
        headPtr           <= headPtr + PTR_W'(1);
        entryVld[headPtr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; only the valid bits are reset, stale payload is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tailPtr] <= '{addr: SQ_MAX_ADDR_W'(pushAddr), data: SQ_MAX_DATA_W'(pushData)};
    end
  end

  assign headAddr = entries[headPtr].addr[ADDR_W-1:0];
  assign headData = entries[headPtr].data[DATA_W-1:0];

  // Any valid entry (including the head awaiting writeack) matching the probed granule.
  always_comb begin
    probeHit = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (entryVld[i] && (((entries[i].addr[ADDR_W-1:0] ^ probeAddr) & LINE_MASK) == '0)) begin
        probeHit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_store_buffer.sv
// Write-back stage: ALU results retire to the register file immediately, stores are posted
// into a small queue and drained to the D-cache in the background.
module wb_store_buffer
  import wb_store_buffer_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int NREGS    = 16,
  parameter int SQ_DEPTH = 4,
  parameter int TAG_W    = 13,
  localparam int REG_W   = $clog2(NREGS),
  localparam int CNT_W   = $clog2(SQ_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kill,
  input  logic [REG_W-1:0]  in_dest_reg,
  input  logic              in_dest_valid,
  input  logic [REG_W-1:0]  in_spec_reg,
  input  logic              in_spec_valid,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_alu_special,
  input  logic              in_is_store,
  input  logic [ADDR_W-1:0] in_store_addr,
  output logic              rf_we0,
  output logic              rf_we1,
  output logic [REG_W-1:0]  rf_waddr0,
  output logic [REG_W-1:0]  rf_waddr1,
  output logic [DATA_W-1:0] rf_wdata0,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic [NREGS-1:0]  busy_clr,
  wb_store_buffer_if.master dc,
  input  logic [ADDR_W-1:0] probe_addr,
  output logic              probe_hit,
  input  logic              fence_req,
  output logic              fence_done,
  output logic [CNT_W-1:0]  sq_count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SQ_DEPTH);
  localparam logic [TAG_W-1:0] REQ_TAG = {WRITE, MEMORY, DATA, {(TAG_W - 3){1'b0}}};

  drain_state_e      state;
  drain_state_e      stateNext;
  logic              live;
  logic              push;
  logic              pop;
  logic              specOverlap;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;
  logic              unusedFence;

  // Fence is purely a wait condition upstream; fence_done alone carries the answer.
  assign unusedFence = fence_req;

  // A pop in the same cycle never frees a slot for a push: no bypass path.
  assign in_ready = in_valid & (in_kill | ~in_is_store | (sq_count < DEPTH_C));
  assign live     = in_ready & ~in_kill;
  assign push     = live & in_is_store;

  wb_store_buffer_sq_fifo #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SQ_DEPTH(SQ_DEPTH)
  ) sqFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushAddr (in_store_addr),
    .pushData (in_alu_result),
    .pop      (pop),
    .headAddr (headAddr),
    .headData (headData),
    .count    (sq_count),
    .probeAddr(probe_addr),
    .probeHit (probe_hit)
  );

  // Register-file writes and scoreboard release for the instruction accepted this cycle.
  always_comb begin
    specOverlap = in_spec_valid & in_dest_valid & (in_spec_reg == in_dest_reg);
    rf_we0      = live & ~in_is_store & in_dest_valid & ~specOverlap;
    rf_we1      = live & ~in_is_store & in_spec_valid;
    rf_waddr0   = in_dest_reg;
    rf_waddr1   = in_spec_reg;
    rf_wdata0   = in_alu_result;
    rf_wdata1   = in_alu_special;
    busy_clr    = '0;
    if (rf_we0 || (push && in_dest_valid)) begin
      busy_clr = busy_clr | (NREGS'(1) << in_dest_reg);
    end
    if (rf_we1) begin
      busy_clr = busy_clr | (NREGS'(1) << in_spec_reg);
    end
  end

  // Drain FSM state register; reset abandons any in-flight write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= DS_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Drain FSM transitions: one outstanding write at a time, strict FIFO order.
  always_comb begin
    stateNext = state;
    case (state)
      DS_IDLE: if (sq_count != '0) stateNext = DS_REQ;
      DS_REQ:  if (dc.reqack) stateNext = dc.writeack ? DS_IDLE : DS_WAIT;
      DS_WAIT: if (dc.writeack) stateNext = DS_IDLE;
      default: stateNext = DS_IDLE;
    endcase
  end

  // Drain FSM outputs: the head payload is stable while REQ because the head only moves on pop.
  always_comb begin
    dc.reqcyc  = (state == DS_REQ);
    dc.req     = dc.reqcyc ? headAddr : '0;
    dc.reqdata = dc.reqcyc ? headData : '0;
    dc.reqtag  = dc.reqcyc ? REQ_TAG : '0;
    pop        = ((state == DS_REQ) && dc.reqack && dc.writeack) ||
                 ((state == DS_WAIT) && dc.writeack);
    fence_done = (sq_count == '0) && (state == DS_IDLE);
  end

endmodule
